// File: rtl/gf2_div_pkg.sv
// ============================================================================
// Module      : gf2_div_pkg
// Description : Shared constants and state encoding for the GF(2) divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gf2_div_pkg;

  localparam int c_N     = 32;
  localparam int c_DEG_W = 5;
  localparam int c_ST_W  = 2;

  localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
  localparam logic [c_ST_W-1:0] c_ST_RUN  = 2'd1;
  localparam logic [c_ST_W-1:0] c_ST_DONE = 2'd2;

endpackage : gf2_div_pkg

`default_nettype wire

// File: rtl/gf2_div_deg.sv
// ============================================================================
// Module      : lnz, gf2_deg
// Description : Leading-one detector and polynomial degree extractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lnz
  import gf2_div_pkg::*;
#(
  parameter int N = c_N
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] onehot
);

  // w_seen[i] is set when any bit above position i is one
  logic [N-1:0] w_seen;

  assign w_seen[N-1] = 1'b0;

  genvar gi;
  generate
    for (gi = N - 2; gi >= 0; gi--) begin : g_seen
      assign w_seen[gi] = w_seen[gi+1] | x[gi+1];
    end
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = x[gi] & ~w_seen[gi];
    end
  endgenerate

endmodule : lnz

module gf2_deg
  import gf2_div_pkg::*;
#(
  parameter int N = c_N
) (
  input  logic [N-1:0]       poly,
  output logic [c_DEG_W-1:0] deg,
  output logic               nonzero
);

  logic [N-1:0] w_onehot;

  lnz #(.N(N)) u_lnz (
    .x      (poly),
    .onehot (w_onehot)
  );

  always_comb begin
    deg = '0;
    for (int i = 0; i < N; i++) begin
      if (w_onehot[i]) deg = deg | c_DEG_W'(i);
    end
  end

  assign nonzero = |poly;

endmodule : gf2_deg

`default_nettype wire

// File: rtl/gf2_div.sv
// ============================================================================
// Module      : gf2_div
// Description : Iterative GF(2) polynomial divider, one reduction per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf2_div
  import gf2_div_pkg::*;
#(
  parameter int N = c_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div0
);

  logic [c_ST_W-1:0]  r_state;
  logic [N-1:0]       r_rem;
  logic [N-1:0]       r_div;
  logic [N-1:0]       r_quo;
  logic               r_div0;

  logic [c_DEG_W-1:0] w_deg_r;
  logic [c_DEG_W-1:0] w_deg_b;
  logic               w_r_nz;
  logic               w_b_nz;
  logic [c_DEG_W-1:0] w_shift;

  gf2_deg #(.N(N)) u_deg_r (
    .poly    (r_rem),
    .deg     (w_deg_r),
    .nonzero (w_r_nz)
  );

  gf2_deg #(.N(N)) u_deg_b (
    .poly    (r_div),
    .deg     (w_deg_b),
    .nonzero (w_b_nz)
  );

  // Only consumed when dr >= db, so the subtraction never wraps.
  assign w_shift = w_deg_r - w_deg_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_rem   <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_rem   <= a;
            r_div   <= b;
            r_quo   <= '0;
            r_div0  <= 1'b0;
            r_state <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (!w_b_nz) begin
            r_div0  <= 1'b1;
            r_state <= c_ST_DONE;
          end else if (!w_r_nz || (w_deg_r < w_deg_b)) begin
            r_state <= c_ST_DONE;
          end else begin
            r_rem <= r_rem ^ (r_div << w_shift);
            r_quo <= r_quo | (N'(1) << w_shift);
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == c_ST_RUN);
  assign done = (r_state == c_ST_DONE);
  assign q    = r_quo;
  assign r    = r_rem;
  assign div0 = r_div0;

endmodule : gf2_div

`default_nettype wire

// File: tb/tb_gf2_div.sv
// ============================================================================
// Module      : tb_gf2_div
// Description : Directed table-driven bench for the GF(2) divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf2_div;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_div0;
    int          exp_lat;
  } vec_t;

  logic        r_clk;
  logic        r_reset;
  logic        r_start;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_div0;

  int n_tests;
  int n_fail;

  vec_t vecs [8];

  gf2_div #(.N(32)) dut (
    .clk   (r_clk),
    .reset (r_reset),
    .start (r_start),
    .a     (r_a),
    .b     (r_b),
    .busy  (w_busy),
    .done  (w_done),
    .q     (w_q),
    .r     (w_r),
    .div0  (w_div0)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation from a negedge; optionally pokes start mid-run.
  // Returns at the negedge one cycle after done.
  task automatic run_op(input vec_t v, input int idx, input int poke_cycle);
    int lat;
    int busy_cnt;
    lat      = -1;
    busy_cnt = 0;
    r_a      = v.a;
    r_b      = v.b;
    r_start  = 1'b1;
    @(posedge r_clk);
    #1 r_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge r_clk);
      if (w_busy) busy_cnt++;
      if (w_done) begin
        lat = c;
        break;
      end
      if (c == poke_cycle) begin
        r_a     = 32'hDEAD_BEEF;
        r_b     = 32'h0000_0003;
        r_start = 1'b1;
      end else begin
        r_start = 1'b0;
      end
    end
    r_start = 1'b0;
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d busy cycles", idx), busy_cnt, v.exp_lat - 1);
    check($sformatf("v%0d q", idx), w_q, v.exp_q);
    check($sformatf("v%0d r", idx), w_r, v.exp_r);
    check($sformatf("v%0d div0", idx), {31'd0, w_div0}, {31'd0, v.exp_div0});
    @(negedge r_clk);
    check($sformatf("v%0d done one-shot", idx), {31'd0, w_done}, 32'd0);
    check($sformatf("v%0d idle busy", idx), {31'd0, w_busy}, 32'd0);
    check($sformatf("v%0d q hold", idx), w_q, v.exp_q);
    check($sformatf("v%0d r hold", idx), w_r, v.exp_r);
  endtask

  initial begin
    int done_seen;
    vec_t v;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{32'h0000_0013, 32'h0000_0003, 32'h0000_000E, 32'h0000_0001, 1'b0, 5};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 32'h0000_0002, 1'b0, 3};
    vecs[2] = '{32'h0000_0003, 32'h0000_0010, 32'h0000_0000, 32'h0000_0003, 1'b0, 2};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34};
    vecs[4] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b1, 2};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 3};
    vecs[6] = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 2};
    vecs[7] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 3};

    r_reset = 1'b0;
    r_start = 1'b1;
    r_a     = 32'h1111_1111;
    r_b     = 32'h0000_0001;
    repeat (3) @(posedge r_clk);
    @(negedge r_clk);
    check("reset busy", {31'd0, w_busy}, 32'd0);
    check("reset done", {31'd0, w_done}, 32'd0);
    check("reset q", w_q, 32'd0);
    check("reset r", w_r, 32'd0);
    check("reset div0", {31'd0, w_div0}, 32'd0);

    // First start coincides with the first edge where reset is released.
    r_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], i, 0);
    end

    // Start re-asserted during RUN must not disturb the active operation.
    run_op(vecs[3], 10, 5);
    run_op(vecs[0], 11, 2);

    // Reset asserted at cycle 10 of a long operation aborts it.
    v       = vecs[3];
    r_a     = v.a;
    r_b     = v.b;
    r_start = 1'b1;
    @(posedge r_clk);
    #1 r_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge r_clk);
      if (c == 10) begin
        check("abort busy before reset", {31'd0, w_busy}, 32'd1);
        r_reset = 1'b0;
        r_start = 1'b1;
      end
    end
    @(negedge r_clk);
    r_reset = 1'b1;
    r_start = 1'b0;
    check("abort busy", {31'd0, w_busy}, 32'd0);
    check("abort done", {31'd0, w_done}, 32'd0);
    check("abort q", w_q, 32'd0);
    check("abort r", w_r, 32'd0);
    check("abort div0", {31'd0, w_div0}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge r_clk);
      if (w_done || w_busy) done_seen++;
    end
    check("abort no done pulse", done_seen, 0);

    run_op(vecs[1], 12, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gf2_div

`default_nettype wire
